seg7_share_arbiter: RTL and testbench

Round-robin arbiter that shares one 7-segment digit between NREQ requesters, e.g. the free-running hex counter, a status source and a debug source. The granted requester owns the display for a minimum dwell period. Its live nibble is decoded to segments and driven to the pad register. A blank gap separates consecutive owners so the display never shows one owner's digit under another owner's grant.

---
 rtl/seg7_share_arbiter.sv | 157 +++++++++++++++
 tb/tb_seg7_share_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_share_arbiter.sv
// Round-robin arbiter sharing one 7-segment digit; owners hold for a dwell period, separated by blank cycles.
// Optional SEG7_SHARE_BLINK_EN adds a per-requester blink input that blanks the second half of the dwell.
module seg7_share_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWELL_CYC = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   digit_in,
`ifdef SEG7_SHARE_BLINK_EN
  input  logic [NREQ-1:0]     blink,
`endif
  output logic [NREQ-1:0]     gnt,
  output logic [2:0]          owner,
  output logic [6:0]          seg_out,
  output logic                busy
);

  localparam int DW = (DWELL_CYC > 2) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [2:0]        owner_q, owner_d;
  logic [6:0]        seg_q, seg_d;
  logic              busy_q, busy_d;
  logic [DW-1:0]     dwell_q, dwell_d;

  logic [7:0]        req_ext;
  logic [3:0]        nib [8];
  logic [2:0]        pick;
  logic              own_req, rival_req;

  assign req_ext = 8'(req);

  // Pad the nibble table to 8 entries so a 3-bit owner index always fits.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nib
      if (gi < NREQ) begin : g_live
        assign nib[gi] = digit_in[4*gi +: 4];
      end else begin : g_pad
        assign nib[gi] = 4'h0;
      end
    end
  endgenerate

`ifdef SEG7_SHARE_BLINK_EN
  logic [7:0] blink_ext;
  assign blink_ext = 8'(blink);
`endif

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  // Scan downward so the requester nearest after the pointer is assigned last and wins.
  always_comb begin
    pick = owner_q;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_ext[3'((int'(owner_q) + k) % NREQ)]) begin
        pick = 3'((int'(owner_q) + k) % NREQ);
      end
    end
  end

  assign own_req   = |(req & gnt_q);
  assign rival_req = |(req & ~gnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= 3'(NREQ - 1);
      seg_q   <= '0;
      busy_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (|req) state_d = HOLD;
      HOLD: begin
        if (!own_req) state_d = GAP;
        else if (dwell_q == DWELL_MAX && rival_req) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = '0;
    seg_d   = '0;
    busy_d  = 1'b0;
    owner_d = owner_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (state_d == HOLD) begin
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          owner_d = pick;
          seg_d   = decode(nib[pick]);
          busy_d  = 1'b1;
          dwell_d = '0;
        end
      end
      HOLD: begin
        if (state_d == HOLD) begin
          gnt_d   = gnt_q;
          busy_d  = 1'b1;
          dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DW'(1);
          seg_d   = decode(nib[owner_q]);
`ifdef SEG7_SHARE_BLINK_EN
          // Test the count being loaded so the blank lines up with the visible dwell value.
          if (blink_ext[owner_q] && int'(dwell_d) >= DWELL_CYC / 2) seg_d = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign seg_out = seg_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_seg7_share_arbiter.sv
// Bench for seg7_share_arbiter: cycle model of the sharing rules plus directed literal scenarios.
// Define SEG7_SHARE_BLINK_EN to also exercise the blink input.
module tb_seg7_share_arbiter;
  localparam int NREQ  = 4;
  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] digit_in;
`ifdef SEG7_SHARE_BLINK_EN
  logic [3:0]  blink;
`endif
  logic [3:0]  gnt;
  logic [2:0]  owner;
  logic [6:0]  seg_out;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_share_arbiter #(.NREQ(NREQ), .DWELL_CYC(DWELL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .digit_in(digit_in),
`ifdef SEG7_SHARE_BLINK_EN
    .blink(blink),
`endif
    .gnt(gnt),
    .owner(owner),
    .seg_out(seg_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tab [16];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tab[d];
  endfunction

  function automatic int next_owner(input int from, input logic [3:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(from + k) % NREQ]) return (from + k) % NREQ;
    end
    return from;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a holder keeps the digit until it lets go or a rival shows up after the full dwell;
  // every handover costs one forced blank cycle before arbitration may run again.
  int         m_ptr = NREQ - 1;
  bit         m_hold = 1'b0;
  int         m_cnt = 0;
  int         m_blank = 0;
  logic [3:0] e_gnt = '0;
  logic [6:0] e_seg = '0;
  int         e_owner = NREQ - 1;
  bit         e_busy = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ptr = NREQ - 1; m_hold = 1'b0; m_cnt = 0; m_blank = 0;
    end else if (m_hold) begin
      if (!req[m_ptr] || (m_cnt == DWELL - 1 && (req & ~(4'b0001 << m_ptr)) != 4'b0)) begin
        m_hold  = 1'b0;
        m_blank = 1;
      end else if (m_cnt < DWELL - 1) begin
        m_cnt++;
      end
    end else if (m_blank > 0) begin
      m_blank--;
    end else if (req != 4'b0) begin
      m_ptr  = next_owner(m_ptr, req);
      m_hold = 1'b1;
      m_cnt  = 0;
    end
    e_gnt   = m_hold ? (4'b0001 << m_ptr) : 4'b0;
    e_busy  = m_hold;
    e_owner = m_ptr;
    e_seg   = m_hold ? seg_of(digit_in[4*m_ptr +: 4]) : 7'h00;
`ifdef SEG7_SHARE_BLINK_EN
    if (m_hold && blink[m_ptr] && m_cnt >= DWELL / 2) e_seg = 7'h00;
`endif
  end

  always @(posedge clk) begin
    #1;
    chk("model_gnt", int'(gnt), int'(e_gnt));
    chk("model_seg", int'(seg_out), int'(e_seg));
    chk("model_owner", int'(owner), e_owner);
    chk("model_busy", int'(busy), int'(e_busy));
  end

  initial begin
    rst_n = 1'b0;
    req = 4'hF;
    digit_in = 16'h5C82;
`ifdef SEG7_SHARE_BLINK_EN
    blink = 4'b0000;
`endif
    repeat (3) @(negedge clk);
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_seg", int'(seg_out), 0);
    chk("reset_owner", int'(owner), 3);
    chk("reset_busy", int'(busy), 0);
    $display("reset: gnt=%b seg=%h owner=%0d busy=%b", gnt, seg_out, owner, busy);

    rst_n = 1'b1;
    @(negedge clk);
    chk("first_gnt", int'(gnt), 1);
    chk("first_seg", int'(seg_out), 'h5B);
    chk("first_owner", int'(owner), 0);
    chk("first_busy", int'(busy), 1);
    $display("first grant: gnt=%b seg=%h", gnt, seg_out);

    // All requesting: 4 granted cycles then 2 blank cycles, owners 0,1,2,3,0
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      chk("rr_gnt", int'(gnt), (k % 6 < 4) ? (1 << ((k / 6) % 4)) : 0);
    end
    @(negedge clk);
    chk("rr_gnt_wrap", int'(gnt), 2);
    $display("round robin: 30 cycles sampled, now gnt=%b", gnt);

    rst_n = 1'b0;
    #1;
    chk("async_gnt", int'(gnt), 0);
    chk("async_seg", int'(seg_out), 0);
    chk("async_owner", int'(owner), 3);
    chk("async_busy", int'(busy), 0);
    $display("async reset mid-hold: gnt=%b busy=%b", gnt, busy);

    req = 4'b0100;
    digit_in = 16'h0A00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("single_gnt", int'(gnt), 4);
    chk("single_seg", int'(seg_out), 'h77);
    chk("single_owner", int'(owner), 2);
    repeat (20) begin
      @(negedge clk);
      chk("single_hold", int'(gnt), 4);
    end
    chk("single_seg_A", int'(seg_out), 'h77);
    digit_in = 16'h0300;
    @(negedge clk);
    chk("single_seg_3", int'(seg_out), 'h4F);
    $display("single requester: gnt=%b seg=%h", gnt, seg_out);

    rst_n = 1'b0;
    req = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("early_gnt0", int'(gnt), 2);
    @(negedge clk);
    chk("early_gnt1", int'(gnt), 2);
    req = 4'b0101;
    @(negedge clk);
    chk("early_gap", int'(gnt), 0);
    chk("early_gap_owner", int'(owner), 1);
    @(negedge clk);
    chk("early_idle", int'(gnt), 0);
    @(negedge clk);
    chk("early_next_gnt", int'(gnt), 4);
    chk("early_next_owner", int'(owner), 2);
    $display("early release: new owner=%0d gnt=%b", owner, gnt);

    rst_n = 1'b0;
    req = 4'b0001;
    digit_in = 16'h0009;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("late_hold_gnt", int'(gnt), 1);
    chk("late_hold_seg", int'(seg_out), 'h6F);
    req = 4'b1001;
    @(negedge clk);
    chk("late_gap", int'(gnt), 0);
    @(negedge clk);
    chk("late_idle", int'(gnt), 0);
    chk("late_idle_seg", int'(seg_out), 0);
    @(negedge clk);
    chk("late_gnt", int'(gnt), 8);
    chk("late_owner", int'(owner), 3);
    $display("late arrival: gnt=%b owner=%0d", gnt, owner);

`ifdef SEG7_SHARE_BLINK_EN
    rst_n = 1'b0;
    req = 4'b0001;
    blink = 4'b0001;
    digit_in = 16'h0008;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("blink_seg", int'(seg_out), (k < 2) ? 'h7F : 0);
    end
    $display("blink: seg=%h after saturation", seg_out);
`endif

    rst_n = 1'b0;
    req = 4'b0000;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
